// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the fetch sequencer and its next-PC selector.
//   fetch_state_t  - fetch controller states
//   redirect_src_t - which source produced the next PC
//   PC_STEP        - sequential PC increment
//   jump_target()  - J/JAL target formed from the PC region and instr[25:0]
//   is_misaligned()- true when a target is not word-aligned
package core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        GAP   = 2'd2,
        DELIV = 2'd3
    } fetch_state_t;

    typedef enum logic [2:0] {
        SRC_SEQ    = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_JUMP   = 3'd2,
        SRC_JR     = 3'd3,
        SRC_EXC    = 3'd4
    } redirect_src_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                                input logic [25:0] index);
        return {pc[31:28], index, 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/next_pc_select.sv
// next_pc_select: combinational next-PC priority mux.
//   pc             in  32  current PC
//   exc            in   1  exception redirect (highest priority)
//   jump_reg       in   1  JR/JALR redirect
//   jr_target      in  32  register-sourced target
//   jump           in   1  J/JAL redirect
//   jump_index     in  26  instr[25:0] of the jump
//   branch_taken   in   1  taken conditional branch
//   branch_target  in  32  branch target
//   next_pc        out 32  selected next PC
//   misaligned     out  1  selected jr/branch target was not word-aligned
module next_pc_select
    import core_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic [31:0] pc,
    input  logic        exc,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    redirect_src_t src;
    logic [31:0]   target;

    always_comb begin
        if (exc)
            src = SRC_EXC;
        else if (jump_reg)
            src = SRC_JR;
        else if (jump)
            src = SRC_JUMP;
        else if (branch_taken)
            src = SRC_BRANCH;
        else
            src = SRC_SEQ;
    end

    always_comb begin
        target     = pc + PC_STEP;
        misaligned = 1'b0;
        case (src)
            SRC_EXC:    target = EXC_VECTOR;
            SRC_JR: begin
                target     = jr_target;
                misaligned = is_misaligned(jr_target);
            end
            SRC_JUMP:   target = jump_target(pc, jump_index);
            SRC_BRANCH: begin
                target     = branch_target;
                misaligned = is_misaligned(branch_target);
            end
            default:    target = pc + PC_STEP;
        endcase
        // A misaligned register/branch target is turned into an exception redirect.
        next_pc = misaligned ? EXC_VECTOR : target;
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC and sequences instruction fetch.
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   imem_req/addr  fetch request and address (address is the PC register)
//   imem_ack/rdata memory response
//   instr_valid/ready/out, pc_out  instruction handed to decode with its PC
//   branch_*, jump*, jr_target     redirect inputs, sampled at the handshake
//   exc            exception request, any cycle
//   misalign_err   pulse when a selected jr/branch target is misaligned
//   fetch_count    number of delivered instructions (wraps)
module pc_fetch_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    input  logic        exc,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         squash;
    logic [31:0]  next_pc;
    logic         sel_misaligned;

    next_pc_select #(
        .EXC_VECTOR(EXC_VECTOR)
    ) u_next_pc_select (
        .pc            (pc),
        .exc           (exc),
        .jump_reg      (jump_reg),
        .jr_target     (jr_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc),
        .misaligned    (sel_misaligned)
    );

    assign imem_addr = pc;

    // Redirects are only acted on in the delivery handshake cycle.
    assign misalign_err = instr_valid & instr_ready & sel_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            squash      <= 1'b0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            pc_out      <= '0;
            fetch_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (exc)
                        pc <= EXC_VECTOR;
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end

                FETCH: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= (squash || exc) ? GAP : DELIV;
                        if (squash || exc) begin
                            // Stale response: drop it and refetch from the vector.
                            pc     <= EXC_VECTOR;
                            squash <= 1'b0;
                        end else begin
                            instr_out   <= imem_rdata;
                            pc_out      <= pc;
                            instr_valid <= 1'b1;
                            fetch_count <= fetch_count + 32'd1;
                        end
                    end else if (exc) begin
                        // Keep the address stable; the response is discarded later.
                        squash <= 1'b1;
                    end
                end

                GAP: begin
                    if (exc)
                        pc <= EXC_VECTOR;
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end

                DELIV: begin
                    if (instr_ready) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        state       <= GAP;
                    end else if (exc) begin
                        pc          <= EXC_VECTOR;
                        instr_valid <= 1'b0;
                        state       <= GAP;
                    end
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

    localparam logic [31:0] EXC_V = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic        jump_reg = 1'b0;
    logic [31:0] jr_target = '0;
    logic        exc = 1'b0;
    logic        misalign_err;
    logic [31:0] fetch_count;

    logic        rdata_override = 1'b0;
    logic [31:0] rdata_value = '0;

    // Memory model: each word encodes the low half of its own address.
    assign imem_rdata = rdata_override ? rdata_value : {16'hA5A5, imem_addr[15:0]};

    pc_fetch_sequencer #(
        .RESET_PC  (32'h0000_0000),
        .EXC_VECTOR(EXC_V)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_index   (jump_index),
        .jump_reg     (jump_reg),
        .jr_target    (jr_target),
        .exc          (exc),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        logic        jr;
        logic [31:0] jr_t;
        logic        j;
        logic [25:0] idx;
        logic        br;
        logic [31:0] br_t;
        logic        ex;
        logic [31:0] exp_next;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    // Called at a negedge; returns at the negedge where the condition holds.
    task automatic wait_req(input string name);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout(name);
    endtask

    task automatic wait_valid(input string name);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout(name);
    endtask

    initial begin
        logic [31:0] addrs[3];
        int          rises[3];
        int          n_addr;
        int          n_rise;
        logic        prev_valid;
        logic [31:0] prev_addr;
        int unsigned exp_count;

        //             jr    jr_t          j     idx          br    br_t          ex    next          mis
        vecs[0]  = '{1'b0, 32'h0,        1'b0, 26'h0,       1'b0, 32'h0,        1'b0, 32'h0000_000C, 1'b0};
        vecs[1]  = '{1'b1, 32'h1000_0040, 1'b0, 26'h0,      1'b0, 32'h0,        1'b0, 32'h1000_0040, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 26'h0000100, 1'b0, 32'h0,        1'b0, 32'h1000_0400, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_2000, 1'b1, 26'h3FFFFFF, 1'b1, 32'h0000_3000, 1'b0, 32'h0000_2000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 26'h0,       1'b1, 32'h0000_0102, 1'b0, EXC_V,         1'b1};
        vecs[5]  = '{1'b0, 32'h0,        1'b0, 26'h0,       1'b1, 32'h0000_0500, 1'b0, 32'h0000_0500, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0601, 1'b0, 26'h0,      1'b0, 32'h0,        1'b0, EXC_V,         1'b1};
        vecs[7]  = '{1'b0, 32'h0,        1'b0, 26'h0,       1'b1, 32'h0000_0102, 1'b1, EXC_V,         1'b0};
        vecs[8]  = '{1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0,      1'b0, 32'h0,        1'b0, 32'hFFFF_FFFC, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,        1'b0, 26'h0,       1'b0, 32'h0,        1'b0, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 26'h3FFFFFF, 1'b0, 32'h0,        1'b0, 32'h0FFF_FFFC, 1'b0};
        vecs[11] = '{1'b0, 32'h0,        1'b1, 26'h0000010, 1'b1, 32'h0000_0102, 1'b0, 32'h0000_0040, 1'b0};

        // ---------------- reset and back-to-back sequential fetch ----------------
        instr_ready = 1'b1;
        imem_ack    = 1'b1;
        repeat (2) @(negedge clk);
        check("reset imem_req", {31'b0, imem_req}, 32'd0);
        check("reset instr_valid", {31'b0, instr_valid}, 32'd0);
        check("reset imem_addr", imem_addr, 32'h0);
        check("reset fetch_count", fetch_count, 32'd0);
        check("reset instr_out", instr_out, 32'd0);
        check("reset misalign_err", {31'b0, misalign_err}, 32'd0);

        rst_n      = 1'b1;
        n_addr     = 0;
        n_rise     = 0;
        prev_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (imem_req === 1'b1 && n_addr < 3) begin
                addrs[n_addr] = imem_addr;
                n_addr++;
            end
            if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
                rises[n_rise] = c;
                n_rise++;
            end
            prev_valid = instr_valid;
            if (n_rise == 3) begin
                instr_ready = 1'b0;
                break;
            end
        end
        if (n_rise != 3 || n_addr != 3) begin
            timeout("sequential startup");
        end else begin
            check("seq addr0", addrs[0], 32'h0);
            check("seq addr1", addrs[1], 32'h4);
            check("seq addr2", addrs[2], 32'h8);
            check("valid spacing 1", rises[1] - rises[0], 32'd3);
            check("valid spacing 2", rises[2] - rises[1], 32'd3);
            check("fetch_count 3", fetch_count, 32'd3);
            check("instr_out at 8", instr_out, 32'hA5A5_0008);
            check("pc_out at 8", pc_out, 32'h8);
        end

        // ---------------- table-driven redirects ----------------
        prev_addr = 32'h8;
        exp_count = 3;
        for (int i = 0; i < 12; i++) begin
            wait_valid("table wait valid");
            check("table pc_out", pc_out, prev_addr);
            check("table instr_out", instr_out, {16'hA5A5, prev_addr[15:0]});
            check("table fetch_count", fetch_count, exp_count);
            jump_reg      = vecs[i].jr;
            jr_target     = vecs[i].jr_t;
            jump          = vecs[i].j;
            jump_index    = vecs[i].idx;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].br_t;
            exc           = vecs[i].ex;
            instr_ready   = 1'b1;
            #1;
            check($sformatf("table[%0d] misalign_err", i), {31'b0, misalign_err}, {31'b0, vecs[i].exp_mis});
            @(negedge clk);
            jump_reg = 1'b0; jump = 1'b0; branch_taken = 1'b0; exc = 1'b0;
            instr_ready = 1'b0;
            check($sformatf("table[%0d] misalign pulse end", i), {31'b0, misalign_err}, 32'd0);
            check($sformatf("table[%0d] gap req", i), {31'b0, imem_req}, 32'd0);
            wait_req("table wait req");
            check($sformatf("table[%0d] next addr", i), imem_addr, vecs[i].exp_next);
            exp_count++;
            prev_addr = vecs[i].exp_next;
        end

        // ---------------- exception while FETCH waits for ack ----------------
        wait_valid("exc-fetch wait valid");
        instr_ready = 1'b1;
        imem_ack    = 1'b0;
        @(negedge clk);
        instr_ready = 1'b0;
        wait_req("exc-fetch wait req");
        check("exc-fetch addr before", imem_addr, 32'h0000_0044);
        exc = 1'b1;
        @(negedge clk);
        exc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("exc-fetch addr held", imem_addr, 32'h0000_0044);
        check("exc-fetch req held", {31'b0, imem_req}, 32'd1);
        imem_ack       = 1'b1;
        rdata_override = 1'b1;
        rdata_value    = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack       = 1'b0;
        rdata_override = 1'b0;
        check("exc-fetch valid after ack", {31'b0, instr_valid}, 32'd0);
        check("exc-fetch gap req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        check("exc-fetch refetch req", {31'b0, imem_req}, 32'd1);
        check("exc-fetch refetch addr", imem_addr, EXC_V);
        check("exc-fetch valid stays 0", {31'b0, instr_valid}, 32'd0);
        check("exc-fetch count", fetch_count, exp_count);
        imem_ack = 1'b1;
        exp_count++;
        @(negedge clk);
        wait_valid("exc-vector delivery");
        check("exc-vector pc_out", pc_out, EXC_V);
        check("exc-vector instr_out", instr_out, 32'hA5A5_0180);

        // ---------------- exception in DELIV without ready ----------------
        exc = 1'b1;
        @(negedge clk);
        exc = 1'b0;
        check("exc-deliv valid dropped", {31'b0, instr_valid}, 32'd0);
        check("exc-deliv gap req", {31'b0, imem_req}, 32'd0);
        check("exc-deliv count", fetch_count, exp_count);
        @(negedge clk);
        check("exc-deliv refetch addr", imem_addr, EXC_V);

        // ---------------- reset asserted mid-FETCH ----------------
        imem_ack = 1'b0;
        @(negedge clk);
        wait_req("reset-midfetch wait req");
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset imem_req", {31'b0, imem_req}, 32'd0);
        check("async reset imem_addr", imem_addr, 32'h0);
        check("async reset instr_valid", {31'b0, instr_valid}, 32'd0);
        check("async reset instr_out", instr_out, 32'd0);
        check("async reset misalign_err", {31'b0, misalign_err}, 32'd0);
        check("async reset fetch_count", fetch_count, 32'd0);
        @(negedge clk);
        imem_ack = 1'b1;
        rst_n    = 1'b1;
        @(negedge clk);
        check("late ack ignored valid", {31'b0, instr_valid}, 32'd0);
        check("post-reset req", {31'b0, imem_req}, 32'd1);
        check("post-reset addr", imem_addr, 32'h0);
        @(negedge clk);
        check("post-reset delivery valid", {31'b0, instr_valid}, 32'd1);
        check("post-reset pc_out", pc_out, 32'h0);
        check("post-reset count", fetch_count, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the single-cycle core.
- Selects the next PC from five sources, with a fixed priority: exception, jump-register, jump, branch, PC+4.
- Drives a req/ack instruction-memory port and hands each instruction to decode over a valid/ready handshake.
- Squashes fetches made stale by an exception, so the datapath's next-PC mux logic is replaced by one registered, stall-aware controller.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- EXC_VECTOR, 32'h8000_0180, redirect target for exceptions and misaligned targets.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals the PC register.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr_out holds a live instruction.
- instr_ready  in  1  decode consumes the instruction this cycle.
- instr_out  out  32  registered instruction.
- pc_out  out  32  PC of instr_out.
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  32  branch target address.
- jump  in  1  J/JAL.
- jump_index  in  26  instr[25:0] of the jump.
- jump_reg  in  1  JR/JALR.
- jr_target  in  32  register-sourced target.
- exc  in  1  exception request; may assert in any cycle.
- misalign_err  out  1  one-cycle pulse: a selected target had bits[1:0] != 0.
- fetch_count  out  32  count of delivered instructions; wraps.

Behaviour:
- Reset (asynchronous, rst_n=0): pc=RESET_PC, state=IDLE, squash=0. Outputs: imem_req=0, instr_valid=0, instr_out=0, misalign_err=0, fetch_count=0.
- State IDLE: moves to FETCH on the first clock edge after reset is released.
- State FETCH: imem_req=1, imem_addr=pc.
  - imem_addr and imem_req stay stable until imem_ack.
  - On ack with squash=0: instr_out<=imem_rdata, pc_out<=pc, instr_valid<=1, fetch_count++, go to DELIV.
  - On ack with squash=1: drop the data, pc<=EXC_VECTOR, squash<=0, go to GAP.
- State GAP: imem_req=0 for exactly one cycle, then FETCH. An ack without a request is ignored.
- State DELIV: instr_valid=1 until the handshake completes. On instr_valid & instr_ready:
  - Next PC by priority:
    - exc: EXC_VECTOR
    - jump_reg: jr_target
    - jump: {pc[31:28], jump_index, 2'b00}
    - branch_taken: branch_target
    - otherwise: pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0)
  - pc<=next, instr_valid<=0, go to GAP, so the request deasserts for one cycle after every delivery.
  - Redirect inputs are sampled only in this handshake cycle.
- Misalignment: if the selected jr_target or branch_target has bits[1:0] != 0, misalign_err=1 for that cycle and next pc=EXC_VECTOR instead.
- exc in FETCH without ack: set squash; the address is held and the pending response is discarded.
- exc in FETCH together with ack: data is discarded, same as the squash path.
- exc in DELIV without ready: instr_valid<=0, pc<=EXC_VECTOR, go to GAP. The instruction is not delivered and fetch_count is not adjusted.
- exc in IDLE or GAP: pc<=EXC_VECTOR.
- Latency: minimum 3 cycles from one delivery to the next (GAP, FETCH with same-cycle ack, DELIV).
- Reset asserted mid-fetch: the outstanding request is abandoned, and a late ack after reset is released is ignored because the block is in IDLE.

Decomposition:
- Shared package core_pkg holds:
  - the state enum (IDLE, FETCH, GAP, DELIV)
  - PC_STEP = 4
  - the redirect-source encoding
- One sub-module, next_pc_select: combinational priority mux, jump-target concatenation and misalignment check. The FSM and registers stay in the top module.

Test Plan:
- Reset release, imem_ack returns in the same cycle as each request, instr_ready=1 throughout:
  - imem_addr sequence is 0x0, 0x4, 0x8.
  - instr_valid rises 3 cycles apart.
  - fetch_count reaches 3.
- pc=0x1000_0040, deliver with jump=1, jump_index=26'h0000100 -> next imem_addr = 0x1000_0400.
- Priority: deliver with jump_reg=1, jr_target=0x2000, jump=1 and branch_taken=1 at the same time -> next imem_addr = 0x2000.
- branch_taken=1, branch_target=0x0000_0102:
  - misalign_err pulses for one cycle.
  - next imem_addr = 0x8000_0180.
- exc pulsed while FETCH waits; ack arrives 3 cycles later with data 0xDEADBEEF:
  - instr_valid stays 0.
  - next request address is 0x8000_0180.
- pc=0xFFFF_FFFC with sequential delivery -> next imem_addr = 0x0000_0000. Separately, rst_n dropped mid-FETCH -> all outputs return to their reset values immediately, without waiting for a clock edge.
